// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the CTR wrapper and its AES-128 core.
// The S-box is derived arithmetically (GF(2^8) inverse plus affine map).
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;
    localparam int AES_LAT     = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        ISSUE,
        WAIT,
        HALT
    } ctr_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] rk,
                                              input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1];
                a2 = s[4*c+2]; a3 = s[4*c+3];
                s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o ^ rk;
    endfunction
endpackage

// File: rtl/aes_ctr_if.sv
// Bundle of the CTR block's control, data and result handshake signals.
// master drives stimulus and consumes results; slave is the CTR block.
interface aes_ctr_if;
    import aes_pkg::*;

    logic                   start_in;
    logic [AES_KEY_W-1:0]   key_in;
    logic [AES_BLOCK_W-1:0] iv_in;
    logic                   data_valid_in;
    logic                   data_ready_out;
    logic [AES_BLOCK_W-1:0] data_in;
    logic                   res_valid_out;
    logic                   res_ready_in;
    logic [AES_BLOCK_W-1:0] res_data_out;
    logic                   busy_out;
    logic                   ctr_wrap_err_out;

    modport master (
        output start_in, key_in, iv_in,
        output data_valid_in, data_in, res_ready_in,
        input  data_ready_out, res_valid_out, res_data_out,
        input  busy_out, ctr_wrap_err_out
    );

    modport slave (
        input  start_in, key_in, iv_in,
        input  data_valid_in, data_in, res_ready_in,
        output data_ready_out, res_valid_out, res_data_out,
        output busy_out, ctr_wrap_err_out
    );
endinterface

// File: rtl/aes_core.sv
// Iterative AES-128 encryptor: one round per cycle, keys expanded on the fly.
// res_valid_out pulses AES_LAT+1 cycles after the data_valid_in cycle.
module aes_core
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   data_valid_in,
    input  logic [AES_BLOCK_W-1:0] data_in,
    input  logic [AES_KEY_W-1:0]   key_in,
    output logic                   res_valid_out,
    output logic [AES_BLOCK_W-1:0] res_enc_out
);
    logic [AES_BLOCK_W-1:0] st_q, st_d;
    logic [AES_KEY_W-1:0]   rk_q, rk_d;
    logic [7:0]             rcon_q;
    logic [3:0]             rnd_q;
    logic                   run_q;
    logic                   vld_q;

    assign rk_d = next_key(rk_q, rcon_q);
    assign st_d = aes_round(st_q, rk_d, rnd_q == 4'(AES_LAT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q   <= '0;
            rk_q   <= '0;
            rcon_q <= '0;
            rnd_q  <= '0;
            run_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (run_q) begin
                st_q   <= st_d;
                rk_q   <= rk_d;
                rcon_q <= xtime(rcon_q);
                rnd_q  <= rnd_q + 4'd1;
                if (rnd_q == 4'(AES_LAT)) begin
                    run_q <= 1'b0;
                    vld_q <= 1'b1;
                end
            end else if (data_valid_in) begin
                st_q   <= data_in ^ key_in;
                rk_q   <= key_in;
                rcon_q <= 8'h01;
                rnd_q  <= 4'd1;
                run_q  <= 1'b1;
            end
        end
    end

    assign res_valid_out = vld_q;
    assign res_enc_out   = st_q;
endmodule

// File: rtl/aes_ctr.sv
// AES-128 CTR engine: one block in flight, results queued in an output FIFO.
// Counter field in the low CTR_W bits; exhausting it halts until a new start.
module aes_ctr
    import aes_pkg::*;
#(
    parameter int CTR_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     resetn,
    aes_ctr_if.slave bus
);
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);

    ctr_state_e             state_q, state_d;
    logic [AES_KEY_W-1:0]   key_q;
    logic [AES_BLOCK_W-1:0] ctr_q;
    logic [AES_BLOCK_W-1:0] din_q;
    logic                   err_q;
    logic [AES_BLOCK_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]            wptr_q, rptr_q, count;

    logic                   fifo_empty;
    logic                   start_ok;
    logic                   hs, push, pop, wrap;
    logic                   core_vld_i, core_vld_o;
    logic [AES_BLOCK_W-1:0] core_res;

    assign count      = wptr_q - rptr_q;
    assign fifo_empty = (count == '0);
    assign start_ok   = bus.start_in && fifo_empty
                        && (state_q inside {IDLE, LOADED, HALT});
    assign hs         = bus.data_valid_in && bus.data_ready_out;
    assign push       = (state_q == WAIT) && core_vld_o;
    assign pop        = bus.res_valid_out && bus.res_ready_in;
    assign wrap       = &ctr_q[CTR_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, HALT: if (start_ok) state_d = LOADED;
            LOADED:     if (hs) state_d = ISSUE;
            ISSUE:      state_d = WAIT;
            WAIT:       if (core_vld_o) state_d = wrap ? HALT : LOADED;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.data_ready_out = 1'b0;
        bus.busy_out       = 1'b0;
        core_vld_i         = 1'b0;
        unique case (state_q)
            LOADED:  bus.data_ready_out = (count < FULL_CNT);
            ISSUE: begin
                bus.busy_out = 1'b1;
                core_vld_i   = 1'b1;
            end
            WAIT:    bus.busy_out = 1'b1;
            default: ;
        endcase
    end

    // A start arriving with a handshake still captures that block
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q  <= '0;
            ctr_q  <= '0;
            din_q  <= '0;
            err_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (start_ok) begin
                key_q <= bus.key_in;
                ctr_q <= bus.iv_in;
                err_q <= 1'b0;
            end
            if (hs) din_q <= bus.data_in;
            if (push) begin
                ctr_q[CTR_W-1:0] <= ctr_q[CTR_W-1:0] + CTR_W'(1);
                if (wrap) err_q <= 1'b1;
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= din_q ^ core_res;
    end

    assign bus.res_valid_out    = !fifo_empty;
    assign bus.res_data_out     = fifo_empty ? '0 : mem_q[rptr_q[PW-1:0]];
    assign bus.ctr_wrap_err_out = err_q;

    aes_core u_core (
        .clk           (clk),
        .resetn        (resetn),
        .data_valid_in (core_vld_i),
        .data_in       (ctr_q),
        .key_in        (key_q),
        .res_valid_out (core_vld_o),
        .res_enc_out   (core_res)
    );
endmodule

// File: doc/aes_ctr.md
AES_CTR -- requirements
Module: aes_ctr

Interface
REQ-001 SHALL have parameter CTR_W, default 32, width of the counter field in the low bits of the counter block; legal range 8..64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of result entries in the output buffer; power of 2, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_in  input  1  one-cycle pulse that loads key_in and iv_in.
REQ-006 SHALL have port key_in  input  128  AES-128 key; sampled only when start_in is accepted.
REQ-007 SHALL have port iv_in  input  128  initial counter block; sampled only when start_in is accepted.
REQ-008 SHALL have port data_valid_in  input  1  an input block is offered.
REQ-009 SHALL have port data_ready_out  output  1  the block can accept an input block.
REQ-010 SHALL have port data_in  input  128  plaintext or ciphertext block.
REQ-011 SHALL have port res_valid_out  output  1  a result is available at the FIFO head.
REQ-012 SHALL have port res_ready_in  input  1  the consumer accepts the result.
REQ-013 SHALL have port res_data_out  output  128  result block, data_in XOR keystream.
REQ-014 SHALL have port busy_out  output  1  a block is in flight (ISSUE or WAIT state).
REQ-015 SHALL have port ctr_wrap_err_out  output  1  sticky counter-exhaustion flag.

Function
REQ-016 SHALL implement a state machine with states IDLE, LOADED, ISSUE, WAIT and HALT.
REQ-017 SHALL accept start_in in IDLE, LOADED or HALT only when the FIFO is empty; an accepted start latches the key, latches ctr=iv_in, clears ctr_wrap_err_out and moves to LOADED.
REQ-018 SHALL ignore start_in in ISSUE or WAIT, or when the FIFO is not empty.
REQ-019 SHALL drive data_ready_out = (state==LOADED) && (FIFO count < FIFO_DEPTH).
REQ-020 SHALL treat a cycle with data_valid_in and data_ready_out both high as an input handshake; on it, capture data_in and move to ISSUE.
REQ-021 SHALL, in ISSUE, drive the aes core for exactly one cycle with data_valid_in=1, data_in=ctr and key_in=the latched key, then move to WAIT.
REQ-022 SHALL, in WAIT, on the cycle the aes core raises res_valid_out, push (captured data XOR aes res_enc_out) into the FIFO.
REQ-023 SHALL, on that same cycle, increment only ctr[CTR_W-1:0] modulo 2^CTR_W and leave ctr[127:CTR_W] unchanged.
REQ-024 SHALL, when the pre-increment counter field was all ones, set ctr_wrap_err_out and move to HALT; otherwise it SHALL move to LOADED.
REQ-025 SHALL hold data_ready_out low in HALT until an accepted start_in.
REQ-026 SHALL allow at most one block in flight at a time.
REQ-027 SHALL keep the FIFO draining in every state, including HALT.
REQ-028 SHALL drive res_valid_out = FIFO not empty and res_data_out = FIFO head.
REQ-029 SHALL pop the FIFO when res_valid_out and res_ready_in are both high.
REQ-030 SHALL deliver results strictly in input order.
REQ-031 SHALL make a pushed result visible at res_valid_out on the cycle after the push.
REQ-032 SHALL, when a push and a pop occur in the same cycle with the FIFO full, perform both without overflow.
REQ-033 SHALL, when a push and a pop occur in the same cycle with the FIFO empty, show the pushed entry the following cycle.
REQ-034 SHALL have input-handshake-to-res_valid_out latency of aes latency + 3 cycles when the FIFO is empty.
REQ-035 SHALL perform encryption and decryption identically, since CTR mode is symmetric; there is no mode port.
REQ-036 SHALL treat data_in, key_in and iv_in as don't-care (X allowed) outside their sampling cycles.

Reset
REQ-037 SHALL, on resetn low, asynchronously go to IDLE, regardless of mid-operation state, and discard any in-flight block.
REQ-038 SHALL, on resetn low, clear the key, ctr and FIFO pointers.
REQ-039 SHALL hold data_ready_out, res_valid_out, busy_out and ctr_wrap_err_out at 0 and res_data_out at 128'h0 while resetn is low.
REQ-040 SHALL reset the instantiated aes core with the same resetn.

Structure
REQ-041 SHALL take the state enum, AES_BLOCK_W=128 and AES_KEY_W=128 from a shared package aes_pkg.
REQ-042 SHALL instantiate exactly one sub-module: the existing aes core.
REQ-043 SHALL implement the FIFO and counter inline.

Verification
REQ-044 SHALL check NIST SP800-38A F.5.1 block 1: key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data 6bc1bee22e409f96e93d7e117393172a -> res 874d6191b620e3261bef6864990db6ce.
REQ-045 SHALL check block 2 of the same vector: data ae2d8a571e03ac9c9eb76fac45af8e51 -> res 9806f66b7970fdff8617187bb9fffdff, with internal counter block f0f1...fcfdff00.
REQ-046 SHALL check decryption: feed 874d6191b620e3261bef6864990db6ce after a start with the same key and iv -> res 6bc1bee22e409f96e93d7e117393172a.
REQ-047 SHALL check backpressure: with res_ready_in held 0 and FIFO_DEPTH=4, exactly 4 blocks are accepted, then data_ready_out stays 0; releasing res_ready_in returns the 4 results in order and data_ready_out rises again.
REQ-048 SHALL check wrap: with CTR_W=8 and iv low byte ff, one block completes, then ctr_wrap_err_out=1 and data_ready_out=0; after a new start_in, ctr_wrap_err_out=0.
REQ-049 SHALL check reset mid-WAIT: drive resetn low -> all outputs read 0 immediately; no stale result appears after reset is released.
